// File: rtl/wb_spi_slave_pkg.sv
// Register map and bit positions shared by the
// wb_spi_slave responder and its users.
package wb_spi_slave_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_CS_ACTIVE = 3;

    localparam int CT_RX_IE = 0;
    localparam int CT_TX_IE = 1;

endpackage

// File: rtl/spi_slave_sync.sv
// N-flop synchroniser with rise/fall pulses
// on the synchronised level.
module spi_slave_sync #(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [stages-1:0] chain;
    logic              prev;

    // Reset to 0 so a falling edge needs a real high first.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[stages-2:0], d};
            prev  <= chain[stages-1];
        end
    end

    assign q    = chain[stages-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone SPI responder, mode 0, MSB first,
// 8-bit frames, single buffered RX and TX.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter int         sync_stages = 2,
    parameter logic [7:0] idle_byte   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    logic sck_q, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;
    logic unused_ok;

    spi_slave_sync #(.stages(sync_stages)) u_sck (
        .clk(clk), .reset(reset), .d(spi_sck),
        .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );

    spi_slave_sync #(.stages(sync_stages)) u_cs (
        .clk(clk), .reset(reset), .d(spi_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_slave_sync #(.stages(sync_stages)) u_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi),
        .q(mosi_q), .rise(mosi_rise_unused),
        .fall(mosi_fall_unused)
    );

    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4],
                         wb_adr_i[1:0], wb_dat_i[31:8],
                         sck_q, cs_q};

    logic [7:0] rx_data, tx_buf, tx_shift;
    logic [6:0] rx_shift;
    logic [2:0] bitcnt;
    logic [1:0] ctrl;
    logic       rx_full, tx_valid, overrun;
    logic [31:0] rdata;

    logic [1:0] adr;
    logic ack_req, acc, rd, wr;
    logic rx_clr, tx_wr, ov_clr, ctrl_wr;
    logic sck_rise_a, sck_fall_a, reload, byte_done;
    logic [7:0] rx_byte, tx_load;

    assign adr     = wb_adr_i[3:2];
    assign ack_req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign acc     = wb_stb_i & wb_cyc_i & wb_ack_o;
    assign rd      = acc & ~wb_we_i;
    assign wr      = acc & wb_we_i;
    assign rx_clr  = rd & (adr == REG_RXDATA);
    assign tx_wr   = wr & (adr == REG_TXDATA);
    assign ctrl_wr = wr & (adr == REG_CTRL);
    assign ov_clr  = wr & (adr == REG_STATUS)
                   & wb_dat_i[ST_OVERRUN];

    // spi_miso_oe doubles as the "frame in progress" flag.
    assign sck_rise_a = spi_miso_oe & sck_rise;
    assign sck_fall_a = spi_miso_oe & sck_fall;
    assign reload     = cs_fall
                      | (sck_fall_a & (bitcnt == 3'd0));
    assign byte_done  = sck_rise_a & (bitcnt == 3'd7);
    assign rx_byte    = {rx_shift, mosi_q};
    assign tx_load    = tx_valid ? tx_buf : idle_byte;

    always_comb begin
        rdata = '0;
        unique case (adr)
            REG_RXDATA: rdata[7:0] = rx_data;
            REG_TXDATA: rdata = '0;
            REG_STATUS: begin
                rdata[ST_RX_FULL]   = rx_full;
                rdata[ST_TX_EMPTY]  = ~tx_valid;
                rdata[ST_OVERRUN]   = overrun;
                rdata[ST_CS_ACTIVE] = spi_miso_oe;
            end
            REG_CTRL:   rdata[1:0] = ctrl;
        endcase
    end

    // Later assignments win: byte store over read-clear,
    // new overrun over clear, TX write over reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            ctrl        <= '0;
            rx_full     <= 1'b0;
            rx_data     <= '0;
            rx_shift    <= '0;
            overrun     <= 1'b0;
            tx_valid    <= 1'b0;
            tx_buf      <= '0;
            tx_shift    <= '0;
            bitcnt      <= '0;
            spi_miso_oe <= 1'b0;
        end else begin
            wb_ack_o <= ack_req;
            wb_dat_o <= (ack_req & ~wb_we_i) ? rdata : '0;
            if (ctrl_wr) ctrl <= wb_dat_i[1:0];
            if (ov_clr)  overrun <= 1'b0;
            if (rx_clr)  rx_full <= 1'b0;
            if (byte_done) begin
                if (!rx_full || rx_clr) begin
                    rx_data <= rx_byte;
                    rx_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (sck_rise_a) begin
                rx_shift <= rx_byte[6:0];
                bitcnt   <= bitcnt + 3'd1;
            end
            if (cs_fall) begin
                spi_miso_oe <= 1'b1;
                bitcnt      <= '0;
            end
            if (reload) begin
                tx_shift <= tx_load;
                tx_valid <= 1'b0;
            end else if (sck_fall_a) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (tx_wr) begin
                tx_buf   <= wb_dat_i[7:0];
                tx_valid <= 1'b1;
            end
            if (cs_rise) begin
                spi_miso_oe <= 1'b0;
                bitcnt      <= '0;
                tx_shift    <= '0;
            end
        end
    end

    assign spi_miso = tx_shift[7];
    assign intr = ((rx_full | overrun) & ctrl[CT_RX_IE])
                | (~tx_valid & ctrl[CT_TX_IE]);

endmodule

// File: tb/tb_wb_spi_slave.sv
// Randomised self-checking bench for wb_spi_slave
// against a register-level reference model.
module tb_wb_spi_slave;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [3:0]  wb_sel_i;
    logic        intr, spi_sck, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic       m_rx_full, m_overrun, m_tx_valid;
    logic [7:0] m_rx_data, m_tx_buf;
    logic [1:0] m_ctrl;

    wb_spi_slave #(.sync_stages(2), .idle_byte(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
        .intr(intr), .spi_sck(spi_sck),
        .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_rx_full = 0; m_overrun = 0; m_tx_valid = 0;
        m_rx_data = 0; m_tx_buf = 0; m_ctrl = 0;
    endfunction

    function automatic logic [7:0] m_reload();
        logic [7:0] b;
        b = m_tx_valid ? m_tx_buf : 8'hFF;
        m_tx_valid = 0;
        return b;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        if (!m_rx_full) begin
            m_rx_data = b;
            m_rx_full = 1;
        end else begin
            m_overrun = 1;
        end
    endfunction

    function automatic logic [31:0] m_status(input logic cs);
        return {28'h0, cs, m_overrun, ~m_tx_valid, m_rx_full};
    endfunction

    function automatic logic m_intr();
        return ((m_rx_full | m_overrun) & m_ctrl[0])
             | (~m_tx_valid & m_ctrl[1]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a,
                           input logic [31:0] d,
                           output logic [31:0] q);
        bit got = 0;
        q = 32'hDEAD_BEEF;
        wb_adr_i = {28'h0, a, 2'b00};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_stb_i = 1;
        wb_cyc_i = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1);
            if (wb_ack_o) begin
                got = 1;
                q = wb_dat_o;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wb_ack_timeout adr=%0d", a);
        end
        tick(1);
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        checks++;
        if (wb_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_width got=%b want=0", wb_ack_o);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'h0, q);
    endtask

    task automatic cs_low();
        spi_cs_n = 0;
        tick(HALF);
    endtask

    task automatic cs_high();
        spi_cs_n = 1;
        tick(6);
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = mo[i];
            tick(HALF);
            mi[i] = spi_miso;
            spi_sck = 1;
            tick(HALF);
            spi_sck = 0;
        end
        tick(4);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset = 1; spi_cs_n = 1; spi_sck = 0; spi_mosi = 0;
        wb_adr_i = 0; wb_dat_i = 0; wb_stb_i = 0;
        wb_cyc_i = 0; wb_we_i = 0; wb_sel_i = 4'hF;
        tick(3);
        checks++;
        if ({wb_ack_o, wb_dat_o, intr, spi_miso, spi_miso_oe} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b dat=%h intr=%b miso=%b oe=%b want all 0",
                     wb_ack_o, wb_dat_o, intr, spi_miso, spi_miso_oe);
        end
        reset = 0;
        m_reset();
        tick(4);
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0)) begin
            errors++;
            $display("FAIL reset_status got=%h want=%h", q, m_status(0));
        end
        wb_read(2'd3, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl got=%h want=0", q);
        end
        wb_read(2'd0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL reset_rxdata got=%h want=0", q);
        end
    endtask

    task automatic test_rx_basic();
        logic [31:0] q;
        logic [7:0]  mi;
        wb_write(2'd3, 32'h1);
        m_ctrl = 2'b01;
        void'(m_reload());
        cs_low();
        spi_byte(8'hA5, mi);
        m_byte(8'hA5);
        void'(m_reload());
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(1)) begin
            errors++;
            $display("FAIL rx_status got=%h want=%h", q, m_status(1));
        end
        checks++;
        if (intr !== m_intr()) begin
            errors++;
            $display("FAIL rx_intr got=%b want=%b", intr, m_intr());
        end
        cs_high();
        wb_read(2'd0, q);
        checks++;
        if (q !== {24'h0, m_rx_data}) begin
            errors++;
            $display("FAIL rx_data got=%h want=%h", q, m_rx_data);
        end
        m_rx_full = 0;
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0) || intr !== m_intr()) begin
            errors++;
            $display("FAIL rx_clear status=%h intr=%b want %h %b",
                     q, intr, m_status(0), m_intr());
        end
    endtask

    task automatic test_tx();
        logic [31:0] q;
        logic [7:0]  mi, exp;
        wb_write(2'd3, 32'h2);
        m_ctrl = 2'b10;
        checks++;
        if (intr !== 1'b1) begin
            errors++;
            $display("FAIL tx_irq_empty got=%b want=1", intr);
        end
        wb_write(2'd1, 32'h3C);
        m_tx_valid = 1; m_tx_buf = 8'h3C;
        checks++;
        if (intr !== 1'b0) begin
            errors++;
            $display("FAIL tx_irq_full got=%b want=0", intr);
        end
        exp = m_reload();
        cs_low();
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(1) || spi_miso_oe !== 1'b1 || intr !== 1'b1) begin
            errors++;
            $display("FAIL tx_cs_fall status=%h oe=%b intr=%b want %h 1 1",
                     q, spi_miso_oe, intr, m_status(1));
        end
        spi_byte(8'h00, mi);
        m_byte(8'h00);
        void'(m_reload());
        checks++;
        if (mi !== exp) begin
            errors++;
            $display("FAIL tx_miso got=%h want=%h", mi, exp);
        end
        cs_high();
        checks++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL tx_cs_rise oe=%b miso=%b want 0 0",
                     spi_miso_oe, spi_miso);
        end
        wb_read(2'd0, q);
        m_rx_full = 0;
        wb_write(2'd3, 32'h0);
        m_ctrl = 0;
    endtask

    task automatic test_two_byte();
        logic [31:0] q;
        logic [7:0]  mi0, mi1;
        void'(m_reload());
        cs_low();
        spi_byte(8'h11, mi0);
        m_byte(8'h11); void'(m_reload());
        spi_byte(8'h22, mi1);
        m_byte(8'h22); void'(m_reload());
        cs_high();
        checks++;
        if (mi0 !== 8'hFF || mi1 !== 8'hFF) begin
            errors++;
            $display("FAIL idle_miso got=%h %h want=ff ff", mi0, mi1);
        end
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0)) begin
            errors++;
            $display("FAIL overrun_status got=%h want=%h", q, m_status(0));
        end
        wb_read(2'd0, q);
        m_rx_full = 0;
        checks++;
        if (q !== {24'h0, m_rx_data}) begin
            errors++;
            $display("FAIL overrun_keep got=%h want=%h", q, m_rx_data);
        end
        wb_write(2'd2, 32'h4);
        m_overrun = 0;
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0)) begin
            errors++;
            $display("FAIL overrun_clear got=%h want=%h", q, m_status(0));
        end
        void'(m_reload());
        cs_low();
        spi_byte(8'h33, mi0);
        m_byte(8'h33); void'(m_reload());
        wb_read(2'd0, q);
        m_rx_full = 0;
        checks++;
        if (q !== 32'h33) begin
            errors++;
            $display("FAIL two_byte_first got=%h want=33", q);
        end
        spi_byte(8'h44, mi1);
        m_byte(8'h44); void'(m_reload());
        cs_high();
        wb_read(2'd0, q);
        m_rx_full = 0;
        checks++;
        if (q !== 32'h44 || m_overrun !== 1'b0) begin
            errors++;
            $display("FAIL two_byte_second got=%h want=44", q);
        end
    endtask

    task automatic test_partial();
        logic [31:0] q;
        logic [7:0]  mi;
        void'(m_reload());
        cs_low();
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            tick(HALF);
            spi_sck = 1;
            tick(HALF);
            spi_sck = 0;
        end
        tick(4);
        cs_high();
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0)) begin
            errors++;
            $display("FAIL partial_status got=%h want=%h", q, m_status(0));
        end
        void'(m_reload());
        cs_low();
        spi_byte(8'h81, mi);
        m_byte(8'h81); void'(m_reload());
        cs_high();
        wb_read(2'd0, q);
        m_rx_full = 0;
        checks++;
        if (q !== 32'h81) begin
            errors++;
            $display("FAIL partial_next got=%h want=81", q);
        end
    endtask

    task automatic test_simul_read();
        logic [31:0] q, rq;
        logic [7:0]  mi, b;
        b = 8'hC3;
        void'(m_reload());
        cs_low();
        spi_byte(8'h5C, mi);
        m_byte(8'h5C); void'(m_reload());
        for (int i = 7; i >= 1; i--) begin
            spi_mosi = b[i];
            tick(HALF);
            spi_sck = 1;
            tick(HALF);
            spi_sck = 0;
        end
        spi_mosi = b[0];
        tick(HALF);
        // read-clear lands on the same clock as the 8th rise
        spi_sck = 1;
        tick(1);
        wb_adr_i = 32'h0; wb_we_i = 0;
        wb_stb_i = 1; wb_cyc_i = 1;
        tick(1);
        rq = wb_dat_o;
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_ack got=%b want=1", wb_ack_o);
        end
        tick(1);
        wb_stb_i = 0; wb_cyc_i = 0;
        tick(HALF - 3);
        spi_sck = 0;
        tick(4);
        cs_high();
        m_rx_data = b;
        checks++;
        if (rq !== 32'h5C) begin
            errors++;
            $display("FAIL simul_old got=%h want=5c", rq);
        end
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0)) begin
            errors++;
            $display("FAIL simul_status got=%h want=%h", q, m_status(0));
        end
        wb_read(2'd0, q);
        m_rx_full = 0;
        checks++;
        if (q !== {24'h0, b}) begin
            errors++;
            $display("FAIL simul_new got=%h want=%h", q, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        logic [7:0]  mi;
        wb_write(2'd3, 32'h3);
        wb_write(2'd1, 32'h77);
        cs_low();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                reset = 1;
                tick(2);
                reset = 0;
                m_reset();
                tick(1);
            end
            spi_mosi = i[0];
            tick(HALF);
            spi_sck = 1;
            tick(HALF);
            spi_sck = 0;
        end
        tick(4);
        checks++;
        if (spi_miso_oe !== 1'b0 || intr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_oe oe=%b intr=%b want 0 0",
                     spi_miso_oe, intr);
        end
        cs_high();
        wb_read(2'd2, q);
        checks++;
        if (q !== m_status(0)) begin
            errors++;
            $display("FAIL reset_mid_status got=%h want=%h", q, m_status(0));
        end
        wb_read(2'd3, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_ctrl got=%h want=0", q);
        end
        void'(m_reload());
        cs_low();
        spi_byte(8'h5A, mi);
        m_byte(8'h5A); void'(m_reload());
        cs_high();
        wb_read(2'd0, q);
        m_rx_full = 0;
        checks++;
        if (q !== 32'h5A || mi !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_frame rx=%h miso=%h want 5a ff", q, mi);
        end
    endtask

    task automatic test_random();
        logic [31:0] q;
        logic [7:0]  mi, b, cur, t;
        int          n;
        for (int it = 0; it < 25; it++) begin
            m_ctrl = 2'($urandom_range(0, 3));
            wb_write(2'd3, {30'h0, m_ctrl});
            if ($urandom_range(0, 1) == 1) begin
                t = 8'($urandom);
                wb_write(2'd1, {24'h0, t});
                m_tx_valid = 1; m_tx_buf = t;
            end
            n = $urandom_range(1, 3);
            cur = m_reload();
            cs_low();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                spi_byte(b, mi);
                checks++;
                if (mi !== cur) begin
                    errors++;
                    $display("FAIL rnd_miso it=%0d k=%0d got=%h want=%h",
                             it, k, mi, cur);
                end
                m_byte(b);
                cur = m_reload();
                if ($urandom_range(0, 2) == 0) begin
                    t = 8'($urandom);
                    wb_write(2'd1, {24'h0, t});
                    m_tx_valid = 1; m_tx_buf = t;
                end
                if ($urandom_range(0, 1) == 1) begin
                    wb_read(2'd0, q);
                    checks++;
                    if (q !== {24'h0, m_rx_data}) begin
                        errors++;
                        $display("FAIL rnd_rx it=%0d got=%h want=%h",
                                 it, q, m_rx_data);
                    end
                    m_rx_full = 0;
                end
            end
            cs_high();
            wb_read(2'd2, q);
            checks++;
            if (q !== m_status(0) || intr !== m_intr()) begin
                errors++;
                $display("FAIL rnd_status it=%0d got=%h intr=%b want=%h %b",
                         it, q, intr, m_status(0), m_intr());
            end
            if ($urandom_range(0, 1) == 1) begin
                wb_write(2'd2, 32'h4);
                m_overrun = 0;
            end
            if ($urandom_range(0, 1) == 1) begin
                wb_read(2'd0, q);
                checks++;
                if (q !== {24'h0, m_rx_data}) begin
                    errors++;
                    $display("FAIL rnd_rx_end it=%0d got=%h want=%h",
                             it, q, m_rx_data);
                end
                m_rx_full = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx();
        test_two_byte();
        test_partial();
        test_simul_read();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
